// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, wait-source encoding and hazard FSM states.
package core_pkg;

   // RV32I major opcodes seen by the hazard logic
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Outstanding-miss source as presented on wait_src
   localparam logic [1:0] WSRC_NONE  = 2'b00;
   localparam logic [1:0] WSRC_IMISS = 2'b01;
   localparam logic [1:0] WSRC_DMISS = 2'b10;

   // Miss-tracking FSM states
   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_IWAIT = 2'b01,
      ST_DWAIT = 2'b10
   } hz_state_e;

   // Map an FSM state to its externally visible wait-source code
   function automatic logic [1:0] state_to_src(input hz_state_e st);
      logic [1:0] src;
      case (st)
         ST_RUN:   src = WSRC_NONE;
         ST_IWAIT: src = WSRC_IMISS;
         ST_DWAIT: src = WSRC_DMISS;
         default:  src = WSRC_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Free-running event counter: +1 on each enabled cycle, wraps modulo 2^CNT_W.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment on enabled cycles, otherwise hold
   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register, cleared by the asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / memory-wait controller: load-use stall, jump/branch flush,
// cache-miss freeze, miss-source FSM, miss watchdog and performance counters.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       D_rs1,
   input  logic [4:0]       D_rs2,
   input  logic             D_use_rs1,
   input  logic             D_use_rs2,
   input  logic [6:0]       E_op,
   input  logic [4:0]       E_rd,
   input  logic             jb,
   input  logic             imem_req,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             stall,
   output logic             jb_flush,
   output logic             waiting,
   output logic [1:0]       wait_src,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam int              WR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WR_W-1:0] TO_V  = WR_W'(TIMEOUT);
   localparam logic [WR_W-1:0] WR_1  = WR_W'(1);

   logic            dmiss_s;
   logic            imiss_s;
   logic            waiting_s;
   logic            jb_flush_s;
   logic            rs1_hit_s;
   logic            rs2_hit_s;
   logic            stall_s;

   hz_state_e       state_q;
   hz_state_e       state_d;
   logic [WR_W-1:0] wait_run_q;
   logic [WR_W-1:0] wait_run_d;
   logic            timeout_err_q;
   logic            timeout_err_d;

   // Same-cycle strobes; priority waiting > jb > stall mirrors the pipeline registers
   always_comb begin
      dmiss_s    = dmem_req & ~dmem_ready;
      imiss_s    = imem_req & ~imem_ready;
      waiting_s  = dmiss_s | imiss_s;
      jb_flush_s = jb & ~waiting_s;
      rs1_hit_s  = D_use_rs1 & (D_rs1 == E_rd);
      rs2_hit_s  = D_use_rs2 & (D_rs2 == E_rd);
      stall_s    = ~waiting_s & ~jb & (E_op == OP_LOAD) & (E_rd != 5'd0)
                   & (rs1_hit_s | rs2_hit_s);
   end

   // Miss-source FSM next state; a pending D-miss wins because it is the older instruction
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (dmiss_s) begin
               state_d = ST_DWAIT;
            end else if (imiss_s) begin
               state_d = ST_IWAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DWAIT: begin
            if (dmiss_s) begin
               state_d = ST_DWAIT;
            end else if (imiss_s) begin
               state_d = ST_IWAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_IWAIT: begin
            if (imiss_s) begin
               state_d = ST_IWAIT;
            end else if (dmiss_s) begin
               state_d = ST_DWAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Watchdog: saturating run length of consecutive waiting cycles, sticky error at TIMEOUT
   always_comb begin
      wait_run_d = wait_run_q;
      if (!waiting_s) begin
         wait_run_d = '0;
      end else if (wait_run_q < TO_V) begin
         wait_run_d = wait_run_q + WR_1;
      end else begin
         wait_run_d = wait_run_q;
      end
      timeout_err_d = timeout_err_q | (wait_run_d == TO_V);
   end

   // FSM and watchdog state registers; reset abandons any outstanding miss at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_RUN;
         wait_run_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_run_q    <= wait_run_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_s),
      .count (stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (jb_flush_s),
      .count (flush_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (waiting_s),
      .count (wait_cnt)
   );

   assign stall       = stall_s;
   assign jb_flush    = jb_flush_s;
   assign waiting     = waiting_s;
   assign wait_src    = state_to_src(state_q);
   assign timeout_err = timeout_err_q;

endmodule
